// File: rtl/ex_mem_buff_pkg.sv
// Shared constants for the EX/MEM pipeline buffer: default payload width
// and the bubble/reset pattern loaded on reset and on flush.
package ex_mem_buff_pkg;

    localparam int          EXMEM_DATA_W_DEF = 16;
    localparam logic [15:0] EXMEM_BUBBLE_VAL = 16'h0000;

endpackage : ex_mem_buff_pkg

// File: rtl/ex_mem_buff_pipe_reg_cell.sv
// pipe_reg_cell: width-parameterised pipeline register with asynchronous
// active-low clear to RST_VAL and a load enable (en=0 holds the value).
module pipe_reg_cell #(
    parameter int           W       = 16,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] q_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q_reg <= RST_VAL;
        end else if (en) begin
            q_reg <= d;
        end
    end

    assign q = q_reg;

endmodule : pipe_reg_cell

// File: rtl/ex_mem_buff.sv
// EX/MEM pipeline buffer: one-edge registered hand-off of the EX result bundle.
// Defining EXMEM_STALL_FLUSH_EN adds stall/flush inputs and a valid_out flag.
module ex_mem_buff
    import ex_mem_buff_pkg::*;
#(
    parameter int                DATA_W  = EXMEM_DATA_W_DEF,
    parameter logic [DATA_W-1:0] RST_VAL = DATA_W'(EXMEM_BUBBLE_VAL)
) (
    input  logic              clk,
    input  logic              rst,
`ifdef EXMEM_STALL_FLUSH_EN
    input  logic              stall,
    input  logic              flush,
    output logic              valid_out,
`endif
    input  logic [DATA_W-1:0] data_in_bus,
    output logic [DATA_W-1:0] data_out_bus
);

    logic              load_en;
    logic [DATA_W-1:0] payload_next;

`ifdef EXMEM_STALL_FLUSH_EN
    logic valid_next;

    // Flush wins over stall: it must load the bubble even while the stage is held.
    always_comb begin
        load_en      = flush | ~stall;
        payload_next = flush ? RST_VAL : data_in_bus;
        valid_next   = ~flush;
    end

    pipe_reg_cell #(
        .W       (1),
        .RST_VAL (1'b0)
    ) u_valid_cell (
        .clk (clk),
        .rst (rst),
        .en  (load_en),
        .d   (valid_next),
        .q   (valid_out)
    );
`else
    always_comb begin
        load_en      = 1'b1;
        payload_next = data_in_bus;
    end
`endif

    pipe_reg_cell #(
        .W       (DATA_W),
        .RST_VAL (RST_VAL)
    ) u_payload_cell (
        .clk (clk),
        .rst (rst),
        .en  (load_en),
        .d   (payload_next),
        .q   (data_out_bus)
    );

endmodule : ex_mem_buff

// File: tb/tb_ex_mem_buff.sv
// Directed self-checking bench for ex_mem_buff; the stall/flush section is
// built only when EXMEM_STALL_FLUSH_EN is defined.
module tb_ex_mem_buff;

    localparam int DATA_W = 16;

    logic              clk;
    logic              rst;
    logic [DATA_W-1:0] data_in_bus;
    logic [DATA_W-1:0] data_out_bus;
`ifdef EXMEM_STALL_FLUSH_EN
    logic              stall;
    logic              flush;
    logic              valid_out;
`endif

    int n_cmp;
    int n_err;

    ex_mem_buff #(
        .DATA_W  (DATA_W),
        .RST_VAL (16'h0000)
    ) dut (
        .clk          (clk),
        .rst          (rst),
`ifdef EXMEM_STALL_FLUSH_EN
        .stall        (stall),
        .flush        (flush),
        .valid_out    (valid_out),
`endif
        .data_in_bus  (data_in_bus),
        .data_out_bus (data_out_bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
        end else begin
            $display("ok   %s: %h (t=%0t)", tag, act, $time);
        end
    endtask

    // Drive an input at the falling edge, then sample just after the next rising edge.
    task automatic step(input logic [DATA_W-1:0] d);
        @(negedge clk);
        data_in_bus = d;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected finish");
        n_err++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $fatal(1, "timeout");
    end

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst = 1'b1;
        data_in_bus = 16'h1234;
`ifdef EXMEM_STALL_FLUSH_EN
        stall = 1'b0;
        flush = 1'b0;
`endif
        // Reset asserted before any clock edge must clear the output at once.
        #1 rst = 1'b0;
        #1;
        check("reset_no_edge", 32'(data_out_bus), 32'h0000);
`ifdef EXMEM_STALL_FLUSH_EN
        check("reset_valid", 32'(valid_out), 32'h0);
        stall = 1'b1;
`endif
        @(posedge clk);
        @(posedge clk);
        #1;
        check("reset_ignores_edges", 32'(data_out_bus), 32'h0000);

        // Release between edges; first edge then captures 0, then 1..15.
        @(negedge clk);
        rst = 1'b1;
        data_in_bus = 16'h0000;
`ifdef EXMEM_STALL_FLUSH_EN
        stall = 1'b0;
`endif
        @(posedge clk);
        #1;
        check("pipe_0", 32'(data_out_bus), 32'h0000);
`ifdef EXMEM_STALL_FLUSH_EN
        check("first_capture_valid", 32'(valid_out), 32'h1);
`endif
        for (int i = 1; i < 16; i++) begin
            @(negedge clk);
            check($sformatf("lag_%0d", i), 32'(data_out_bus), 32'(i - 1));
            data_in_bus = 16'(i);
            @(posedge clk);
            #1;
            check($sformatf("pipe_%0d", i), 32'(data_out_bus), 32'(i));
        end

        // No combinational path: mid-cycle input change stays invisible.
        step(16'h00AA);
        check("hold_aa", 32'(data_out_bus), 32'h00AA);
        #2 data_in_bus = 16'h0055;
        #1;
        check("no_comb_path", 32'(data_out_bus), 32'h00AA);
        @(posedge clk);
        #1;
        check("capture_55", 32'(data_out_bus), 32'h0055);

        // Mid-cycle reset pulse discards the held value immediately.
        step(16'h000F);
        check("hold_0f", 32'(data_out_bus), 32'h000F);
        #2 rst = 1'b0;
        #1;
        check("mid_reset_clear", 32'(data_out_bus), 32'h0000);
        data_in_bus = 16'h0033;
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("after_release", 32'(data_out_bus), 32'h0000);
        @(posedge clk);
        #1;
        check("capture_after_reset", 32'(data_out_bus), 32'h0033);

        step(16'hFFFF);
        check("full_width", 32'(data_out_bus), 32'hFFFF);

`ifdef EXMEM_STALL_FLUSH_EN
        step(16'h0007);
        check("pre_stall_data", 32'(data_out_bus), 32'h0007);
        check("pre_stall_valid", 32'(valid_out), 32'h1);

        @(negedge clk);
        stall = 1'b1;
        data_in_bus = 16'h0008;
        @(posedge clk);
        #1;
        check("stall_hold_data", 32'(data_out_bus), 32'h0007);
        check("stall_hold_valid", 32'(valid_out), 32'h1);

        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        check("flush_prio_data", 32'(data_out_bus), 32'h0000);
        check("flush_prio_valid", 32'(valid_out), 32'h0);

        @(negedge clk);
        flush = 1'b0;
        stall = 1'b1;
        data_in_bus = 16'h0021;
        @(posedge clk);
        #1;
        check("stall_bubble_valid", 32'(valid_out), 32'h0);

        @(negedge clk);
        stall = 1'b0;
        data_in_bus = 16'h0009;
        @(posedge clk);
        #1;
        check("resume_data", 32'(data_out_bus), 32'h0009);
        check("resume_valid", 32'(valid_out), 32'h1);

        @(negedge clk);
        flush = 1'b1;
        data_in_bus = 16'h00BB;
        @(posedge clk);
        #1;
        check("flush_only_data", 32'(data_out_bus), 32'h0000);
        check("flush_only_valid", 32'(valid_out), 32'h0);
        @(negedge clk);
        flush = 1'b0;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_ex_mem_buff

// File: doc/ex_mem_buff.md
EX_MEM_BUFF -- requirements
Module: ex_mem_buff

Interface
REQ-001 SHALL have parameter DATA_W, default 16, meaning the payload width in bits.
REQ-002 SHALL have parameter RST_VAL, default all-zeros of DATA_W, meaning the value loaded into the payload on reset and on flush.
REQ-003 SHALL have port clk, input, 1 bit, the single clock; all storage updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit; one clock; reset is asynchronous and active-low.
REQ-005 SHALL have port data_in_bus, input, DATA_W bits, the EX-stage result and control bundle to be latched.
REQ-006 SHALL have port data_out_bus, output, DATA_W bits, the registered bundle presented to the MEM stage.
REQ-007 SHALL have port stall, input, 1 bit, hold request; present only when EXMEM_STALL_FLUSH_EN is defined.
REQ-008 SHALL have port flush, input, 1 bit, bubble-insert request; present only when EXMEM_STALL_FLUSH_EN is defined.
REQ-009 SHALL have port valid_out, output, 1 bit, high when data_out_bus holds a real instruction, not a bubble or reset value; present only when EXMEM_STALL_FLUSH_EN is defined.

Function
REQ-010 SHALL capture data_in_bus into data_out_bus on every rising clk edge while rst=1, subject to REQ-014 to REQ-016.
REQ-011 SHALL have a latency of exactly one rising edge: a value applied before edge N appears on data_out_bus after edge N and holds until edge N+1.
REQ-012 SHALL NOT pass data_in_bus changes between edges to data_out_bus; there is no combinational path from input to output.
REQ-013 SHALL drive data_out_bus only from the register, with no glitches other than at the clock edge or on reset assertion.
REQ-014 With the macro defined, when flush=1 at an edge, data_out_bus SHALL load RST_VAL and valid_out SHALL load 0.
REQ-015 With the macro defined, when stall=1 and flush=0 at an edge, data_out_bus and valid_out SHALL hold their values.
REQ-016 With the macro defined, flush SHALL take priority over stall when both are 1 at the same edge.
REQ-017 With the macro defined, a normal capture (stall=0, flush=0) SHALL set valid_out to 1.
REQ-018 SHALL apply the full DATA_W width unchanged, with no truncation, sign handling or arithmetic on the payload.

Reset
REQ-019 Asserting rst=0 SHALL immediately force data_out_bus to RST_VAL and valid_out to 0, independent of clk.
REQ-020 While rst=0, clock edges, data_in_bus, stall and flush SHALL have no effect.
REQ-021 After rst rises, the first rising edge SHALL capture data_in_bus normally.
REQ-022 Reset asserted mid-operation SHALL discard the held value without waiting for an edge.

Configuration
REQ-023 The macro EXMEM_STALL_FLUSH_EN, when defined, SHALL add stall, flush and valid_out with the behaviour of REQ-014 to REQ-017.
REQ-024 When EXMEM_STALL_FLUSH_EN is undefined, those three ports SHALL be absent and the block SHALL be a plain one-stage register.

Structure
REQ-025 A shared package SHALL hold the default DATA_W (16) and the default reset/bubble constant (16'h0000).
REQ-026 The storage SHALL be a single sub-module, pipe_reg_cell, implementing one width-parameterised register with async active-low clear and a hold enable. ex_mem_buff instantiates it for the payload and, when the macro is defined, a 1-bit instance for valid_out.

Verification
REQ-027 Assert rst=0 with no clock edge, data_in_bus=16'h1234 -> data_out_bus=16'h0000 immediately.
REQ-028 Set rst=1, clk period 10, data_in_bus=0,1,...,15, changing every 10 time units -> after each rising edge data_out_bus equals the value applied before that edge, lagging the input by one edge.
REQ-029 Change data_in_bus from 16'h00AA to 16'h0055 between edges -> data_out_bus stays 16'h00AA until the next rising edge.
REQ-030 Hold data_out_bus=16'h000F, then pulse rst=0 mid-cycle -> data_out_bus=16'h0000 at once; after rst=1, the next edge captures the current input.
REQ-031 With EXMEM_STALL_FLUSH_EN defined, start from data_out_bus=16'h0007 with valid_out=1:
- stall=1 with input 16'h0008 -> output holds 16'h0007.
- flush=1 and stall=1 together -> output 16'h0000, valid_out=0.
- next edge with both inputs 0 -> valid_out=1.
